seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised Moore serial-pattern detector; successor to the fixed 4-bit "1011" detector.
- Run-time programmable pattern (length 1..N), selectable overlap/non-overlap mode, enable gating, saturating match counter, config-error flag.
- Sits on a single-bit serial input stream and drives a one-cycle registered match pulse to downstream FSM/test logic.

Parameters:
- N, 8, maximum pattern length in bits (N >= 2)
- LW, $clog2(N+1), width of len port
- CNT_W, 16, width of the match counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- cfg_load  in  1  latch pattern/len/overlap; clears detection history
- pattern  in  N  pattern bits; pattern[len-1] is the first-received bit, pattern[0] the last
- len  in  LW  pattern length, valid range 1..N
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- en  in  1  sample x this cycle when high
- x  in  1  serial data input
- clr_count  in  1  synchronous clear of count
- z  out  1  Moore match output, registered
- count  out  CNT_W  number of matches, saturating
- cfg_err  out  1  latched len is 0 or > N

Behaviour:
- Reset (reset=0, async): hist=0, fill=0, cfg_pat=0, cfg_len=0, cfg_ovl=0, state=FILL, z=0, count=0, cfg_err=1 (len 0 is invalid). Takes effect immediately, mid-stream included; no partial match survives.
- Config: on cfg_load=1, at the clock edge: cfg_pat<=pattern, cfg_len<=len, cfg_ovl<=overlap, cfg_err<=(len==0 || len>N), hist<=0, fill<=0, state<=FILL, z<=0. x is ignored that cycle even if en=1; count is unchanged. Between loads, live pattern/len/overlap inputs have no effect.
- History: when en=1 and cfg_load=0: hist<={hist[N-2:0],x}, so hist[0] is the newest bit; fill<=min(fill+1,N).
- Match condition, evaluated on the next-state values: cfg_err=0, fill_next>=cfg_len, hist_next[cfg_len-1:0]==cfg_pat[cfg_len-1:0]. Upper bits are masked.
- States, Moore, z decoded from state:
  - FILL: fill < cfg_len; z=0.
  - HUNT: armed, no match on the last sampled bit; z=0.
  - MATCH: the last sampled bit completed the pattern; z=1.
- Transitions on en=1:
  - Any state goes to MATCH on the match condition, otherwise to HUNT if fill_next>=cfg_len, otherwise to FILL.
  - Non-overlap mode: on entering MATCH, fill<=0 (the overrides fill+1), so the next match needs cfg_len fresh bits. The state after MATCH is then FILL.
  - Overlap mode: fill is retained, so back-to-back matches are allowed.
- en=0: hist and fill are held; state goes to HUNT if fill>=cfg_len, else FILL. z therefore drops after one cycle and is never a stretched pulse.
- Latency: z is high for exactly the one clock cycle following the rising edge that sampled the completing bit.
- count:
  - Increments by 1 on each entry to MATCH; holds at 2^CNT_W-1.
  - clr_count sets count to 0. If clr_count and a match occur in the same cycle, count=1.
  - cfg_load and clr_count in the same cycle: both actions apply.
- cfg_err=1: z is never asserted and count never increments.
- len==N: the full history register is compared.

Test Plan:
- Baseline 1011: reset, load pattern=8'h0B, len=4, overlap=1; stream 1,0,1,1,0,1,1 with en=1 → z high in the cycle after bit 4 and after bit 7, low otherwise; count=2.
- Non-overlap: same config with overlap=0, same stream → z only after bit 4; count=1. Then stream 0,1,1 → count=2.
- Mode/length generality: load pattern=8'hFF, len=8, overlap=1; stream 10 ones → z after bits 8, 9, 10; count=3. Reload len=1, pattern=1; stream 1,0,1 → z after bits 1 and 3.
- Enable gating and mid-stream reset:
  - pattern 1011, stream 1,0,1, then hold en=0 for 3 cycles, then 1 → z low during the stall and z=1 after the final bit.
  - Repeat, but pulse reset=0 asynchronously mid-stream after bits 1,0,1, then reload the config and send 1 → no z; count=0.
- Config error: load len=0 → cfg_err=1; stream 1011 → z never high, count=0. Load len=9 with N=8 → cfg_err=1. Load a valid config → cfg_err=0.
- Counter saturation/clear: CNT_W=2, len=1, pattern=1; send 5 ones → count 1,2,3,3,3. Assert clr_count together with a matching bit → count=1.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: config, serial-stream and result signals of the pattern detector
// master drives cfg_load/pattern/len/overlap/en/x/clr_count and observes z/count/cfg_err; slave is the detector side
interface seq_detector_param_if #(
    parameter int N = 8,
    parameter int LW = $clog2(N + 1),
    parameter int CNT_W = 16
);
    logic cfg_load, overlap, en, x, clr_count, z, cfg_err;
    logic [N-1:0] pattern;
    logic [LW-1:0] len;
    logic [CNT_W-1:0] count;
    modport master (output cfg_load, pattern, len, overlap, en, x, clr_count, input z, count, cfg_err);
    modport slave (input cfg_load, pattern, len, overlap, en, x, clr_count, output z, count, cfg_err);
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param: programmable Moore serial-pattern detector with overlap mode, saturating match counter and config-error flag
// clk rising edge; reset async active-low; bus (slave): cfg_load latches pattern/len/overlap, en samples x, clr_count clears count,
// z is the one-cycle match pulse, count the saturating match total, cfg_err flags a latched len of 0 or above N
module seq_detector_param #(
    parameter int N = 8,
    parameter int LW = $clog2(N + 1),
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    seq_detector_param_if.slave bus
);
    typedef enum logic [1:0] {FILL, HUNT, MATCH} state_t;
    state_t state, state_nx;
    // only N-1 old bits are ever visible in the next-state window, so the oldest bit is not stored
    logic [N-2:0] hist;
    logic [N-1:0] hist_nx, cfg_pat, mask;
    logic [LW-1:0] fill, fill_inc, cfg_len;
    logic cfg_ovl, cfg_err, hit;
    logic [CNT_W-1:0] count, cnt_base;

    always_comb begin
        hist_nx = {hist, bus.x};
        fill_inc = (fill >= LW'(N)) ? LW'(N) : fill + LW'(1);
        mask = (cfg_len >= LW'(N)) ? '1 : (N'(1) << cfg_len) - N'(1);
        hit = !cfg_err && fill_inc >= cfg_len && ((hist_nx ^ cfg_pat) & mask) == '0;
        cnt_base = bus.clr_count ? '0 : count;
    end

    always_comb begin
        state_nx = bus.cfg_load ? FILL :
                   bus.en ? (hit ? MATCH : (fill_inc >= cfg_len ? HUNT : FILL)) :
                   (fill >= cfg_len ? HUNT : FILL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FILL;
        else state <= state_nx;
    end

    always_comb begin
        bus.z = (state == MATCH);
        bus.count = count;
        bus.cfg_err = cfg_err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
            cfg_pat <= '0;
            cfg_len <= '0;
            cfg_ovl <= 1'b0;
            cfg_err <= 1'b1;
            count <= '0;
        end else begin
            count <= (bus.en && !bus.cfg_load && hit && !(&cnt_base)) ? cnt_base + CNT_W'(1) : cnt_base;
            if (bus.cfg_load) begin
                cfg_pat <= bus.pattern;
                cfg_len <= bus.len;
                cfg_ovl <= bus.overlap;
                cfg_err <= bus.len == '0 || bus.len > LW'(N);
                hist <= '0;
                fill <= '0;
            end else if (bus.en) begin
                hist <= hist_nx[N-2:0];
                // non-overlap: a match consumes its bits, the next one needs cfg_len fresh samples
                fill <= (hit && !cfg_ovl) ? '0 : fill_inc;
            end
        end
    end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: table-driven, directed and randomized checks of seq_detector_param against a bit-queue reference model
module tb_seq_detector_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_detector_param_if #(.N(8), .CNT_W(16)) b8 ();
    seq_detector_param_if #(.N(8), .CNT_W(2)) b2 ();
    seq_detector_param #(.N(8), .CNT_W(16)) d8 (.clk(clk), .reset(reset), .bus(b8));
    seq_detector_param #(.N(8), .CNT_W(2)) d2 (.clk(clk), .reset(reset), .bus(b2));

    int passed = 0;
    int total = 0;

    typedef struct {
        bit ld;
        logic [7:0] p;
        logic [3:0] l;
        bit ov, e, b, clr;
        bit ez, eerr;
        int ec16, ec2;
    } vec_t;
    vec_t tbl[$];

    bit q[$];
    logic [7:0] m_pat;
    int m_len, m_c16, m_c2;
    bit m_ovl, m_err, m_z;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic model_reset;
        q.delete();
        m_pat = '0;
        m_len = 0;
        m_ovl = 1'b0;
        m_err = 1'b1;
        m_z = 1'b0;
        m_c16 = 0;
        m_c2 = 0;
    endtask

    task automatic model_step(bit ld, logic [7:0] p, logic [3:0] l, bit ov, bit e, bit b, bit clr);
        bit hit;
        hit = 1'b0;
        if (ld) begin
            m_pat = p;
            m_len = int'(l);
            m_ovl = ov;
            m_err = (l == 0 || l > 8);
            q.delete();
        end else if (e) begin
            q.push_back(b);
            if (q.size() > 8) void'(q.pop_front());
            if (!m_err && q.size() >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (q[q.size() - 1 - i] != m_pat[i]) hit = 1'b0;
            end
            if (hit && !m_ovl) q.delete();
        end
        m_z = hit;
        if (clr) begin
            m_c16 = 0;
            m_c2 = 0;
        end
        if (hit) begin
            if (m_c16 < 65535) m_c16++;
            if (m_c2 < 3) m_c2++;
        end
    endtask

    task automatic drv(bit ld, logic [7:0] p, logic [3:0] l, bit ov, bit e, bit b, bit clr);
        b8.cfg_load = ld; b8.pattern = p; b8.len = l; b8.overlap = ov; b8.en = e; b8.x = b; b8.clr_count = clr;
        b2.cfg_load = ld; b2.pattern = p; b2.len = l; b2.overlap = ov; b2.en = e; b2.x = b; b2.clr_count = clr;
    endtask

    task automatic cyc(bit ld, logic [7:0] p, logic [3:0] l, bit ov, bit e, bit b, bit clr);
        drv(ld, p, l, ov, e, b, clr);
        @(posedge clk);
        model_step(ld, p, l, ov, e, b, clr);
        #1;
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".z8"}, b8.z, m_z);
        chk({tag, ".z2"}, b2.z, m_z);
        chk({tag, ".count16"}, b8.count, m_c16);
        chk({tag, ".count2"}, b2.count, m_c2);
        chk({tag, ".err8"}, b8.cfg_err, m_err);
        chk({tag, ".err2"}, b2.cfg_err, m_err);
    endtask

    task automatic areset(string tag);
        #2 reset = 1'b0;
        #1 model_reset();
        chk({tag, ".rst_z"}, b8.z, 0);
        chk({tag, ".rst_count16"}, b8.count, 0);
        chk({tag, ".rst_count2"}, b2.count, 0);
        chk({tag, ".rst_err"}, b8.cfg_err, 1);
        #2 reset = 1'b1;
    endtask

    task automatic add(bit ld, logic [7:0] p, logic [3:0] l, bit ov, bit e, bit b, bit clr,
                       bit ez, bit eerr, int c16, int c2);
        vec_t v;
        v.ld = ld; v.p = p; v.l = l; v.ov = ov; v.e = e; v.b = b; v.clr = clr;
        v.ez = ez; v.eerr = eerr; v.ec16 = c16; v.ec2 = c2;
        tbl.push_back(v);
    endtask

    task automatic s(bit b, bit ez, bit eerr, int c16, int c2);
        add(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, 1'b0, ez, eerr, c16, c2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk("reset.z", b8.z, 0);
        chk("reset.count", b8.count, 0);
        chk("reset.err", b8.cfg_err, 1);
        reset = 1'b1;

        // baseline 1011, overlap
        add(1, 8'h0B, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        s(1, 0, 0, 0, 0); s(0, 0, 0, 0, 0); s(1, 0, 0, 0, 0); s(1, 1, 0, 1, 1);
        s(0, 0, 0, 1, 1); s(1, 0, 0, 1, 1); s(1, 1, 0, 2, 2);
        // non-overlap, load and clear together
        add(1, 8'h0B, 4, 0, 0, 0, 1, 0, 0, 0, 0);
        s(1, 0, 0, 0, 0); s(0, 0, 0, 0, 0); s(1, 0, 0, 0, 0); s(1, 1, 0, 1, 1);
        s(0, 0, 0, 1, 1); s(1, 0, 0, 1, 1); s(1, 0, 0, 1, 1);
        s(0, 0, 0, 1, 1); s(1, 0, 0, 1, 1); s(1, 1, 0, 2, 2);
        // full-width pattern, len = N
        add(1, 8'hFF, 8, 1, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++)
            s(1, i >= 8, 0, i >= 8 ? i - 7 : 0, i >= 8 ? i - 7 : 0);
        // len = 1
        add(1, 8'h01, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        s(1, 1, 0, 1, 1); s(0, 0, 0, 1, 1); s(1, 1, 0, 2, 2);
        // enable gating: stall must not disturb history, z never stretches
        add(1, 8'h0B, 4, 1, 0, 0, 1, 0, 0, 0, 0);
        s(1, 0, 0, 0, 0); s(0, 0, 0, 0, 0); s(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        s(1, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        // config errors
        add(1, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 0);
        s(1, 0, 1, 0, 0); s(0, 0, 1, 0, 0); s(1, 0, 1, 0, 0); s(1, 0, 1, 0, 0);
        add(1, 8'h0B, 9, 1, 0, 0, 0, 0, 1, 0, 0);
        s(1, 0, 1, 0, 0);
        add(1, 8'h0B, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        // saturation and clear
        add(1, 8'h01, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        s(1, 1, 0, 1, 1); s(1, 1, 0, 2, 2); s(1, 1, 0, 3, 3); s(1, 1, 0, 4, 3); s(1, 1, 0, 5, 3);
        add(0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1);
        add(1, 8'h01, 1, 1, 1, 1, 0, 0, 0, 1, 1);
        s(1, 1, 0, 2, 2);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            cyc(tbl[k].ld, tbl[k].p, tbl[k].l, tbl[k].ov, tbl[k].e, tbl[k].b, tbl[k].clr);
            chk($sformatf("vec%0d.z8", k), b8.z, tbl[k].ez);
            chk($sformatf("vec%0d.z2", k), b2.z, tbl[k].ez);
            chk($sformatf("vec%0d.count16", k), b8.count, tbl[k].ec16);
            chk($sformatf("vec%0d.count2", k), b2.count, tbl[k].ec2);
            chk($sformatf("vec%0d.err", k), b8.cfg_err, tbl[k].eerr);
        end

        // asynchronous reset mid-stream wipes the partial match and the count
        cyc(1, 8'h0B, 4, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1, 0); cyc(0, 0, 0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1, 1, 0); cyc(0, 0, 0, 0, 1, 1, 0);
        chk("mid.pre_count", b8.count, 1);
        cyc(0, 0, 0, 0, 1, 1, 0); cyc(0, 0, 0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1, 1, 0);
        areset("mid");
        cyc(1, 8'h0B, 4, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0);
        chk("mid.z", b8.z, 0);
        chk("mid.count", b8.count, 0);
        chk("mid.err", b8.cfg_err, 0);

        for (int i = 0; i < 600; i++) begin
            int r;
            logic [3:0] l;
            r = $urandom_range(0, 199);
            if (r == 0) areset($sformatf("rnd%0d", i));
            l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(1, 3));
            cyc(r < 8, 8'($urandom), l, 1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
                $urandom_range(0, 39) == 0);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
